relu_maxpool_stream: RTL and testbench
======================================

Name: relu_maxpool_stream

Overview:
- Downstream consumer of the 5x5 convolution stage.
- Takes the raster-order stream of saturated signed 16-bit convolution results and discards samples whose window overlaps the image border.
- Applies ReLU, then 2x2/stride-2 max pooling, and requantizes to 8 bits.
- The output oX/oValid stream has the same format as the convolution stage's iX input, so the next conv layer can consume it directly.

Parameters:
- DW_IN, 16, input sample width (signed).
- DW_OUT, 8, output sample width (signed, result always non-negative).
- IMG_W, 32, input frame width in samples (one sample per iValid).
- IMG_H, 32, input frame height in rows.
- K, 5, kernel size; valid region is (IMG_W-K+1) x (IMG_H-K+1) = 28x28, and both dimensions must be even.
- SHIFT, 4, right-shift applied before saturation to DW_OUT.

Ports:
- iCLK  input  1  clock.
- iRST  input  1  synchronous reset, active-high.
- iClear  input  1  synchronous frame resync; zeroes the position counters.
- iY  input  DW_IN  signed conv result.
- iValid  input  1  iY valid this cycle.
- oX  output  DW_OUT  pooled, requantized sample, range 0..2^(DW_OUT-1)-1.
- oValid  output  1  oX valid, single-cycle per sample.
- oLast  output  1  high together with oValid for the final pooled sample of a frame.
- oFrameDone  output  1  one-cycle pulse after the last input sample of a frame.

Behaviour:
- Reset: when iRST=1 on a clock edge, oX=0, oValid=0, oLast=0, oFrameDone=0, col=0, row=0, and the hold register is 0. The line buffer is not cleared; every entry is rewritten on an even pooled row before it is read.
- Position tracking: col is 0..IMG_W-1 and row is 0..IMG_H-1, both advancing only on iValid. col wraps to 0 and row increments. When col=IMG_W-1 and row=IMG_H-1, both wrap to 0 and oFrameDone pulses on the next cycle.
- Gaps in iValid are allowed anywhere; state holds during a gap.
- Valid region: a sample is used only when col>=K-1 and row>=K-1, giving vc=col-(K-1) and vr=row-(K-1). All other samples are dropped and do not touch the hold register or the line buffer.
- ReLU: r = (iY<0) ? 0 : iY.
- Horizontal stage:
  - vc even: hold <= r.
  - vc odd: hmax = max(hold, r).
- Vertical stage, on odd vc only:
  - vr even: lbuf[vc>>1] <= hmax. lbuf has (IMG_W-K+1)/2 = 14 entries of DW_IN-1 bits.
  - vr odd: m = max(lbuf[vc>>1], hmax); emit the output.
- Requantize: q = m >> SHIFT (logical shift, m >= 0). If q > 2^(DW_OUT-1)-1, q is clamped to 2^(DW_OUT-1)-1.
- Output timing: oX/oValid are registered and appear exactly 1 cycle after the iValid edge that carried the bottom-right sample of a 2x2 window.
  - oValid is otherwise 0.
  - oX holds its last value when oValid is 0.
- oLast is asserted with the output whose vc = IMG_W-K and vr = IMG_H-K (pooled index 195 of 196).
- oFrameDone is independent of oValid. It may coincide with oLast+oValid on the same cycle; for the defaults both fire 1 cycle after sample 1023.
- Per frame: exactly ((IMG_W-K+1)/2)*((IMG_H-K+1)/2) = 196 outputs.
- iClear: col and row go to 0 on the next edge.
  - If iClear and iValid are both high, clear wins and the sample is dropped: no output, no oFrameDone.
  - Any in-flight oValid or oFrameDone already registered still appears.
- iRST mid-frame: same as iClear, and all outputs are forced to 0 on the next cycle.
- No backpressure: the downstream stage must accept one sample per cycle.

Test Plan:
- Reset: hold iRST 3 cycles with iValid toggling -> oX=0, oValid=0, oLast=0, oFrameDone=0 throughout; after release, col and row start from 0.
- Constant frame: 1024 samples of iY=100 back-to-back -> 196 pulses of oValid with oX=6.
  - First oValid 1 cycle after input sample index 5*32+5=165.
  - oLast and oFrameDone both 1 cycle after sample 1023.
- ReLU and saturation:
  - Frame of iY=-500 -> 196 outputs, all oX=0.
  - Frame of iY=5000 -> all oX=127.
  - Frame of iY=32767 -> all oX=127.
- Max selection: zero frame except samples (col,row) = (4,4)=16, (5,4)=-32, (4,5)=48, (5,5)=320 -> first output oX=20 (320>>4), all other outputs 0.
  - Repeat with 320 moved to (4,4) -> first output still 20.
- Gapped input: constant frame iY=100 with iValid high every 3rd cycle -> identical 196 outputs of 6; each oValid exactly 1 cycle after its triggering iValid.
- Clear mid-frame: feed 600 samples, assert iClear together with iValid, then feed a full frame of iY=64 -> exactly 196 outputs of oX=4, one oLast, one oFrameDone; the dropped sample produces no output.

Source files
------------

// File: rtl/relu_maxpool_stream_if.sv
// Sample stream between the conv stage and the ReLU/max-pool stage:
// raw conv results in, pooled 8-bit samples plus frame markers out.
interface relu_maxpool_stream_if #(
  parameter int DW_IN  = 16,
  parameter int DW_OUT = 8
);
  logic signed [DW_IN-1:0]  iY;
  logic                     iValid;
  logic signed [DW_OUT-1:0] oX;
  logic                     oValid;
  logic                     oLast;
  logic                     oFrameDone;

  modport master (
    output iY, iValid,
    input  oX, oValid, oLast, oFrameDone
  );

  modport slave (
    input  iY, iValid,
    output oX, oValid, oLast, oFrameDone
  );
endinterface

// File: rtl/relu_maxpool_stream.sv
// ReLU + 2x2/stride-2 max pooling over the border-free region of a raster
// conv result stream, requantized to DW_OUT bits for the next conv layer.
module relu_maxpool_stream #(
  parameter int DW_IN  = 16,
  parameter int DW_OUT = 8,
  parameter int IMG_W  = 32,
  parameter int IMG_H  = 32,
  parameter int K      = 5,
  parameter int SHIFT  = 4
) (
  input logic iCLK,
  input logic iRST,
  input logic iClear,
  relu_maxpool_stream_if.slave bus
);
  localparam int CW   = $clog2(IMG_W);
  localparam int RW   = $clog2(IMG_H);
  localparam int LB   = (IMG_W - K + 1) / 2;
  localparam int MW   = DW_IN - 1;
  localparam int QMAX = 2 ** (DW_OUT - 1) - 1;

  logic [CW-1:0]     col, vc;
  logic [RW-1:0]     row, vr;
  logic [CW-2:0]     lidx;
  logic              in_win, last_in, emit, lb_wr;
  logic [MW-1:0]     r, hold, hmax, lb_rd, m, q;
  logic [DW_OUT-2:0] qsat;
  logic [MW-1:0]     lbuf [LB];

  assign vc      = col - CW'(K - 1);
  assign vr      = row - RW'(K - 1);
  assign in_win  = (col >= CW'(K - 1)) && (row >= RW'(K - 1));
  assign last_in = (col == CW'(IMG_W - 1)) && (row == RW'(IMG_H - 1));
  assign lidx    = vc[CW-1:1];

  // ReLU output is non-negative, so the sign bit can be dropped
  assign r     = bus.iY[DW_IN-1] ? '0 : bus.iY[MW-1:0];
  assign hmax  = (r > hold) ? r : hold;
  assign lb_rd = lbuf[lidx];
  assign m     = (lb_rd > hmax) ? lb_rd : hmax;
  assign q     = m >> SHIFT;
  assign qsat  = (q > MW'(QMAX)) ? (DW_OUT-1)'(QMAX) : q[DW_OUT-2:0];

  assign emit  = bus.iValid && !iClear && in_win && vc[0] && vr[0];
  assign lb_wr = bus.iValid && !iClear && in_win && vc[0] && !vr[0];

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      col            <= '0;
      row            <= '0;
      hold           <= '0;
      bus.oX         <= '0;
      bus.oValid     <= 1'b0;
      bus.oLast      <= 1'b0;
      bus.oFrameDone <= 1'b0;
    end else begin
      bus.oValid     <= 1'b0;
      bus.oLast      <= 1'b0;
      bus.oFrameDone <= 1'b0;
      if (iClear) begin
        col <= '0;
        row <= '0;
      end else if (bus.iValid) begin
        if (col == CW'(IMG_W - 1)) begin
          col <= '0;
          row <= (row == RW'(IMG_H - 1)) ? '0 : row + RW'(1);
        end else begin
          col <= col + CW'(1);
        end
        bus.oFrameDone <= last_in;
        if (in_win && !vc[0]) hold <= r;
        if (emit) begin
          bus.oX     <= {1'b0, qsat};
          bus.oValid <= 1'b1;
          bus.oLast  <= (vc == CW'(IMG_W - K)) && (vr == RW'(IMG_H - K));
        end
      end
    end
  end

  // No reset: every entry is written on an even pooled row before being read
  always_ff @(posedge iCLK) begin
    if (!iRST && lb_wr) lbuf[lidx] <= hmax;
  end
endmodule

// File: tb/tb_relu_maxpool_stream.sv
// Scoreboard bench: a window-max reference model predicts each pooled sample
// and its cycle; a negedge monitor pops and compares DUT output.
module tb_relu_maxpool_stream;
  logic iCLK = 1'b0;
  logic iRST = 1'b1;
  logic iClear = 1'b0;

  relu_maxpool_stream_if #(.DW_IN(16), .DW_OUT(8)) bus ();

  relu_maxpool_stream dut (
    .iCLK   (iCLK),
    .iRST   (iRST),
    .iClear (iClear),
    .bus    (bus)
  );

  always #5 iCLK = ~iCLK;

  typedef struct {
    int x;
    int last;
    int due;
  } exp_t;

  exp_t exp_q[$];
  int   fd_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   ocnt = 0, lcnt = 0, fcnt = 0, first_x = -1;
  bit   rst_phase = 1'b1;
  int   mcol = 0, mrow = 0;
  int   img [32][32];

  always @(posedge iCLK) cyc <= cyc + 1;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int relu(input int v);
    return (v < 0) ? 0 : v;
  endfunction

  function automatic int win_exp(input int c, input int r);
    int mx;
    mx = relu(img[r-1][c-1]);
    if (relu(img[r-1][c]) > mx) mx = relu(img[r-1][c]);
    if (relu(img[r][c-1]) > mx) mx = relu(img[r][c-1]);
    if (relu(img[r][c]) > mx) mx = relu(img[r][c]);
    mx = mx >> 4;
    return (mx > 127) ? 127 : mx;
  endfunction

  task automatic send(input bit v, input int y, input bit clr);
    @(posedge iCLK);
    #1;
    bus.iValid = v;
    bus.iY     = 16'(y);
    iClear     = clr;
    if (clr) begin
      mcol = 0;
      mrow = 0;
    end else if (v) begin
      img[mrow][mcol] = int'($signed(16'(y)));
      if (mcol >= 5 && mrow >= 5 && (mcol % 2) == 1 && (mrow % 2) == 1)
        exp_q.push_back('{win_exp(mcol, mrow), int'(mcol == 31 && mrow == 31), cyc + 1});
      if (mcol == 31 && mrow == 31) fd_q.push_back(cyc + 1);
      if (mcol == 31) begin
        mcol = 0;
        mrow = (mrow == 31) ? 0 : mrow + 1;
      end else begin
        mcol++;
      end
    end
  endtask

  task automatic clear_counts();
    ocnt = 0;
    lcnt = 0;
    fcnt = 0;
    first_x = -1;
  endtask

  task automatic frame(input int base, input int mode, input int gap);
    int y;
    for (int r = 0; r < 32; r++) begin
      for (int c = 0; c < 32; c++) begin
        y = base;
        if (mode == 1 && r == 4 && c == 4) y = 16;
        if (mode == 1 && r == 4 && c == 5) y = -32;
        if (mode == 1 && r == 5 && c == 4) y = 48;
        if (mode == 1 && r == 5 && c == 5) y = 320;
        if (mode == 2 && r == 4 && c == 4) y = 320;
        if (mode == 2 && r == 4 && c == 5) y = -32;
        if (mode == 2 && r == 5 && c == 4) y = 48;
        if (mode == 2 && r == 5 && c == 5) y = 16;
        send(1'b1, y, 1'b0);
        for (int g = 0; g < gap; g++) send(1'b0, 0, 1'b0);
      end
    end
    repeat (3) send(1'b0, 0, 1'b0);
  endtask

  task automatic frame_summary(input string tag, input int first_exp);
    check({tag, "_n_out"}, ocnt, 196);
    check({tag, "_n_last"}, lcnt, 1);
    check({tag, "_n_fdone"}, fcnt, 1);
    check({tag, "_first_x"}, first_x, first_exp);
    check({tag, "_q_empty"}, exp_q.size(), 0);
    clear_counts();
  endtask

  always @(negedge iCLK) begin
    if (!rst_phase) begin
      if (bus.oValid) begin
        if (ocnt == 0) first_x = int'(bus.oX);
        ocnt++;
        if (bus.oLast) lcnt++;
        if (exp_q.size() == 0) begin
          check("spurious_out", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("out_cycle", cyc, e.due);
          check("oX", int'(bus.oX), e.x);
          check("oLast", int'(bus.oLast), e.last);
        end
      end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
        check("missed_out", 0, 1);
        void'(exp_q.pop_front());
      end
      if (!bus.oValid && bus.oLast) check("oLast_no_valid", 1, 0);
      if (bus.oFrameDone) begin
        fcnt++;
        check("fdone_cycle", cyc, (fd_q.size() > 0) ? fd_q[0] : -1);
        if (fd_q.size() > 0) void'(fd_q.pop_front());
      end else if (fd_q.size() > 0 && fd_q[0] <= cyc) begin
        check("missed_fdone", 0, 1);
        void'(fd_q.pop_front());
      end
    end
  end

  initial begin
    bus.iValid = 1'b0;
    bus.iY     = '0;
    for (int i = 0; i < 3; i++) begin
      @(posedge iCLK);
      #1;
      bus.iValid = (i % 2 == 1);
      bus.iY     = 16'sd1000;
      @(negedge iCLK);
      check("rst_oX", int'(bus.oX), 0);
      check("rst_oValid", int'(bus.oValid), 0);
      check("rst_oLast", int'(bus.oLast), 0);
      check("rst_oFrameDone", int'(bus.oFrameDone), 0);
    end
    @(posedge iCLK);
    #1;
    iRST = 1'b0;
    bus.iValid = 1'b0;
    rst_phase = 1'b0;

    frame(100, 0, 0);    frame_summary("const100", 6);
    frame(-500, 0, 0);   frame_summary("neg500", 0);
    frame(5000, 0, 0);   frame_summary("sat5000", 127);
    frame(32767, 0, 0);  frame_summary("sat32767", 127);
    frame(0, 1, 0);      frame_summary("max_br", 20);
    frame(0, 2, 0);      frame_summary("max_tl", 20);
    frame(100, 0, 2);    frame_summary("gapped", 6);

    for (int i = 0; i < 600; i++) send(1'b1, 100, 1'b0);
    send(1'b1, 77, 1'b1);
    repeat (3) send(1'b0, 0, 1'b0);
    check("pre_clear_q_empty", exp_q.size(), 0);
    clear_counts();
    frame(64, 0, 0);     frame_summary("after_clear", 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
